// File: rtl/icache_axi_responder_if.sv
// rtl/icache_axi_responder_if.sv - AR/R channel bundle between the icache refill master and the read responder
interface icache_axi_responder_if #(
  parameter int DATA_BYTES = 8,
  parameter int ID_W       = 4
);
  logic                    mar_valid;
  logic [ID_W-1:0]         mar_id;
  logic [31:0]             mar_addr;
  logic [7:0]              mar_len;
  logic [2:0]              mar_size;
  logic [1:0]              mar_burst;
  logic                    sar_ready;

  logic                    sr_valid;
  logic [ID_W-1:0]         sr_id;
  logic [8*DATA_BYTES-1:0] sr_data;
  logic [1:0]              sr_resp;
  logic                    sr_last;
  logic                    mr_ready;

  modport master (
    output mar_valid, mar_id, mar_addr, mar_len, mar_size, mar_burst, mr_ready,
    input  sar_ready, sr_valid, sr_id, sr_data, sr_resp, sr_last
  );

  modport slave (
    input  mar_valid, mar_id, mar_addr, mar_len, mar_size, mar_burst, mr_ready,
    output sar_ready, sr_valid, sr_id, sr_data, sr_resp, sr_last
  );

  modport axi (
    input  mar_valid, mar_id, mar_addr, mar_len, mar_size, mar_burst, mr_ready,
    output sar_ready, sr_valid, sr_id, sr_data, sr_resp, sr_last
  );
endinterface

// File: rtl/icache_axi_responder.sv
// rtl/icache_axi_responder.sv - AXI4 read responder: AR queue, burst address generator, credit-gated R buffer
module icache_axi_responder #(
  parameter int DATA_BYTES = 8,
  parameter int MEM_BYTES  = 65536,
  parameter int AR_DEPTH   = 2,
  parameter int ID_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  icache_axi_responder_if.axi          axi,
  output logic                         mem_en,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  input  logic [8*DATA_BYTES-1:0]      mem_rdata
);
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MA_W = $clog2(MEM_BYTES);
  localparam int AP_W = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
  localparam int AC_W = AP_W + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } ar_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
    logic [1:0]      resp;
    logic            last;
  } r_t;

  typedef enum logic {IDLE, BURST} state_t;

  ar_t             ar_q [AR_DEPTH];
  ar_t             ar_head;
  logic [AP_W-1:0] ar_wr, ar_rd;
  logic [AC_W-1:0] ar_count, ar_count_next;
  logic            ar_push, ar_pop, ar_ready;

  r_t              rb [2];
  logic            rb_wr, rb_rd;
  logic [1:0]      rb_count;
  logic            rb_pop;
  logic            rb_valid;

  state_t          state;
  logic [31:0]     cur_addr;
  logic [7:0]      beats_left, b_len;
  logic [ID_W-1:0] b_id;
  logic [2:0]      b_size;
  logic [1:0]      b_burst;
  logic            b_err;

  logic            inflight, if_err, if_last;
  logic [ID_W-1:0] if_id;

  logic            beat_err, issue, last_beat;
  logic [2:0]      occupancy;
  logic [31:0]     step, bound, next_addr;

  assign ar_head       = ar_q[ar_rd];
  assign ar_push       = axi.mar_valid && ar_ready;
  assign last_beat     = (beats_left == 8'd0);
  assign beat_err      = b_err || (cur_addr >= 32'(MEM_BYTES));
  assign rb_valid      = (rb_count != 2'd0);
  assign rb_pop        = rb_valid && axi.mr_ready;

  // A beat issued now lands one cycle later, so reserve its slot against what is already owed.
  assign occupancy     = 3'(rb_count) + 3'(inflight) - 3'(rb_pop);
  assign issue         = (state == BURST) && (occupancy < 3'd2);
  assign ar_pop        = (ar_count != '0) && ((state == IDLE) || (issue && last_beat));
  assign ar_count_next = ar_count + AC_W'(ar_push) - AC_W'(ar_pop);

  always_comb begin
    step  = 32'd1 << b_size;
    bound = step * (32'(b_len) + 32'd1);
    case (b_burst)
      2'b00:   next_addr = cur_addr;
      2'b10:   next_addr = (cur_addr & ~(bound - 32'd1)) | ((cur_addr + step) & (bound - 32'd1));
      default: next_addr = cur_addr + step;
    endcase
  end

  assign mem_en   = issue && !beat_err;
  assign mem_addr = cur_addr[MA_W-1:0] & ~MA_W'(DATA_BYTES - 1);

  assign axi.sar_ready = ar_ready;
  assign axi.sr_valid  = rb_valid;
  assign axi.sr_id     = rb_valid ? rb[rb_rd].id   : '0;
  assign axi.sr_data   = rb_valid ? rb[rb_rd].data : '0;
  assign axi.sr_resp   = rb_valid ? rb[rb_rd].resp : 2'b00;
  assign axi.sr_last   = rb_valid ? rb[rb_rd].last : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ar_wr      <= '0;
      ar_rd      <= '0;
      ar_count   <= '0;
      ar_ready   <= 1'b1;
      rb_wr      <= 1'b0;
      rb_rd      <= 1'b0;
      rb_count   <= 2'd0;
      inflight   <= 1'b0;
      if_err     <= 1'b0;
      if_last    <= 1'b0;
      if_id      <= '0;
      cur_addr   <= 32'd0;
      beats_left <= 8'd0;
      b_len      <= 8'd0;
      b_id       <= '0;
      b_size     <= 3'd0;
      b_burst    <= 2'b00;
      b_err      <= 1'b0;
    end else begin
      if (ar_push) begin
        ar_q[ar_wr] <= '{id: axi.mar_id, addr: axi.mar_addr, len: axi.mar_len,
                         size: axi.mar_size, burst: axi.mar_burst};
        ar_wr       <= ar_wr + AP_W'(1);
      end
      if (ar_pop) ar_rd <= ar_rd + AP_W'(1);
      ar_count <= ar_count_next;
      ar_ready <= (ar_count_next < AC_W'(AR_DEPTH));

      inflight <= issue;
      if_err   <= beat_err;
      if_last  <= last_beat;
      if_id    <= b_id;

      // Error beats still occupy a slot so that every burst returns exactly len+1 beats.
      if (inflight) begin
        rb[rb_wr] <= '{id: if_id, data: (if_err ? '0 : mem_rdata),
                       resp: (if_err ? 2'b10 : 2'b00), last: if_last};
        rb_wr     <= ~rb_wr;
      end
      if (rb_pop) rb_rd <= ~rb_rd;
      rb_count <= rb_count + 2'(inflight) - 2'(rb_pop);

      case (state)
        IDLE:  if (ar_pop) state <= BURST;
        BURST: if (issue && last_beat && !ar_pop) state <= IDLE;
      endcase

      if (ar_pop) begin
        cur_addr   <= ar_head.addr;
        beats_left <= ar_head.len;
        b_len      <= ar_head.len;
        b_id       <= ar_head.id;
        b_size     <= ar_head.size;
        b_burst    <= ar_head.burst;
        b_err      <= (ar_head.burst == 2'b11);
      end else if (issue && !last_beat) begin
        beats_left <= beats_left - 8'd1;
        cur_addr   <= next_addr;
      end
    end
  end
endmodule

// File: tb/tb_icache_axi_responder.sv
// tb/tb_icache_axi_responder.sv - randomized and directed bench with a beat-level reference model
module tb_icache_axi_responder;
  localparam int DATA_BYTES = 8;
  localparam int MEM_BYTES  = 65536;
  localparam int ID_W       = 4;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata = '0;

  int    n_tests = 0, n_fail = 0, cyc = 0;
  beat_t exp_q[$];
  int    pop_cyc[$];
  int    ready_mode = 0;
  int    issued_cnt = 0, popped_cnt = 0, mem_en_cnt = 0, last_hs = 0;
  bit    chk_out = 0;
  bit    stall_prev = 0;
  beat_t held, cur;

  icache_axi_responder_if #(.DATA_BYTES(DATA_BYTES), .ID_W(ID_W)) axi_if ();

  icache_axi_responder #(
    .DATA_BYTES(DATA_BYTES), .MEM_BYTES(MEM_BYTES), .AR_DEPTH(2), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .axi(axi_if),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 3;
    return {16'hC0DE, idx[15:0], idx * 32'h9E3779B9};
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= mem_word({16'h0, mem_addr});

  function automatic logic [31:0] next_a(input logic [31:0] a, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    longint step, bound, base;
    step  = longint'(1) << size;
    bound = step * (longint'(len) + 1);
    case (burst)
      2'b00: return a;
      2'b10: begin
        base = longint'(a) - (longint'(a) % bound);
        return 32'(base + ((longint'(a) - base + step) % bound));
      end
      default: return a + 32'(step);
    endcase
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int n);
    logic [31:0] x;
    x = a;
    for (int i = 0; i < n; i++) x = next_a(x, len, size, burst);
    return x;
  endfunction

  task automatic model_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    beat_t b;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.last = (i == int'(len));
      if (burst == 2'b11 || a >= 32'(MEM_BYTES)) begin
        b.resp = 2'b10;
        b.data = '0;
      end else begin
        b.resp = 2'b00;
        b.data = mem_word(a);
      end
      exp_q.push_back(b);
      a = next_a(a, len, size, burst);
    end
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, expv);
    end
  endtask

  always @(negedge clk) begin
    cur = {axi_if.sr_id, axi_if.sr_data, axi_if.sr_resp, axi_if.sr_last};
    if (!rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) check("hold", cur, held);
      if (chk_out) check("outstanding_le_2", ((issued_cnt - popped_cnt) <= 2), 1);
      if (mem_en) begin
        issued_cnt++;
        mem_en_cnt++;
      end
      if (axi_if.sr_valid && axi_if.mr_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rbeat: got unexpected beat %0h required none", cur);
        end else begin
          check("rbeat", cur, exp_q.pop_front());
        end
        popped_cnt++;
        pop_cyc.push_back(cyc);
      end
      stall_prev = axi_if.sr_valid && !axi_if.mr_ready;
      held = cur;
    end
  end

  initial begin
    int ph;
    ph = 0;
    axi_if.mr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: axi_if.mr_ready = 1'b1;
        1: begin axi_if.mr_ready = (ph % 3 == 0); ph++; end
        2: axi_if.mr_ready = ($urandom_range(0, 3) != 0);
        default: axi_if.mr_ready = 1'b0;
      endcase
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit must, output bit ok);
    int limit;
    limit = must ? 400 : 20;
    ok = 0;
    axi_if.mar_valid = 1'b1;
    axi_if.mar_id    = id;
    axi_if.mar_addr  = addr;
    axi_if.mar_len   = len;
    axi_if.mar_size  = size;
    axi_if.mar_burst = burst;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      ok = axi_if.sar_ready;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    axi_if.mar_valid = 1'b0;
    if (ok) begin
      last_hs = cyc;
      model_burst(id, addr, len, size, burst);
    end else if (must) begin
      n_tests++;
      n_fail++;
      $display("FAIL ar_handshake: got no handshake for id %0d in %0d cycles required handshake", id, limit);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !axi_if.sr_valid) begin
        done = 1;
        break;
      end
    end
    check("drain_done", done, 1);
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bit          ok;
    int          t0, accepted;
    logic [31:0] a;
    logic [7:0]  ln;
    logic [2:0]  sz;
    logic [1:0]  bu;

    axi_if.mar_valid = 1'b0;
    axi_if.mar_id    = '0;
    axi_if.mar_addr  = '0;
    axi_if.mar_len   = '0;
    axi_if.mar_size  = '0;
    axi_if.mar_burst = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sar_ready", axi_if.sar_ready, 1);
    check("rst_sr_valid", axi_if.sr_valid, 0);
    check("rst_sr_last", axi_if.sr_last, 0);
    check("rst_sr_resp", axi_if.sr_resp, 0);
    check("rst_sr_data", axi_if.sr_data, 0);
    check("rst_sr_id", axi_if.sr_id, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    check("pin_mem_word", mem_word(32'h100), 64'hC0DE0020_C6EF3720);
    check("pin_wrap_b1", beat_addr(32'h118, 3, 3, 2'b10, 1), 32'h100);
    check("pin_wrap_b3", beat_addr(32'h118, 3, 3, 2'b10, 3), 32'h110);
    check("pin_incr_wrap", beat_addr(32'hFFFF_FFF8, 1, 3, 2'b01, 1), 32'h0);

    send_ar(5, 32'h100, 3, 3, 2'b01, 1, ok);
    check("incr_last_flags", {exp_q[0].last, exp_q[1].last, exp_q[2].last, exp_q[3].last}, 4'b0001);
    t0 = last_hs;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (axi_if.sr_valid) break;
    end
    check("first_rvalid_latency", cyc - t0, 3);
    drain();

    send_ar(6, 32'h118, 3, 3, 2'b10, 1, ok);
    drain();

    ready_mode = 1;
    issued_cnt = 0;
    popped_cnt = 0;
    chk_out    = 1;
    send_ar(5, 32'h100, 3, 3, 2'b01, 1, ok);
    drain();
    chk_out    = 0;
    ready_mode = 0;

    mem_en_cnt = 0;
    send_ar(7, 32'(MEM_BYTES - 8), 1, 3, 2'b01, 1, ok);
    check("oor_model_resp1", exp_q[1].resp, 2'b10);
    drain();
    check("oor_mem_en_count", mem_en_cnt, 1);

    send_ar(8, 32'hFFFF_FFF8, 1, 3, 2'b01, 1, ok);
    drain();

    pop_cyc.delete();
    send_ar(1, 32'h40, 0, 3, 2'b01, 1, ok);
    send_ar(2, 32'h48, 0, 3, 2'b01, 1, ok);
    send_ar(3, 32'h50, 0, 3, 2'b01, 1, ok);
    drain();
    check("queue_beats", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) check("queue_no_bubble", pop_cyc[2] - pop_cyc[0], 2);

    ready_mode = 3;
    accepted = 0;
    for (int i = 1; i <= 6; i++) begin
      send_ar(4'(i), 32'h80 + 32'(8 * i), 0, 3, 2'b01, 0, ok);
      if (ok) accepted++;
    end
    check("ar_accepted_before_full", accepted, 5);
    @(negedge clk);
    check("sar_ready_full", axi_if.sar_ready, 0);
    ready_mode = 0;
    drain();

    pop_cyc.delete();
    send_ar(9, 32'h200, 7, 3, 2'b01, 1, ok);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pop_cyc.size() >= 2) break;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_sr_valid", axi_if.sr_valid, 0);
    check("midrst_sar_ready", axi_if.sar_ready, 1);
    check("midrst_mem_en", mem_en, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    send_ar(10, 32'h300, 1, 3, 2'b01, 1, ok);
    drain();

    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      bu = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 3));
      if (bu == 2'b10) begin
        case ($urandom_range(0, 3))
          0: ln = 8'd1;
          1: ln = 8'd3;
          2: ln = 8'd7;
          default: ln = 8'd15;
        endcase
      end else begin
        ln = 8'($urandom_range(0, 7));
      end
      a = 32'($urandom_range(0, MEM_BYTES + 32'h200));
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      a = a & ~((32'd1 << sz) - 32'd1);
      send_ar(4'($urandom_range(0, 15)), a, ln, sz, bu, 1, ok);
    end
    drain();
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
